// File: rtl/result_stream_packer_if.sv
// Stream bundle for result_stream_packer: per-channel sample inputs on one
// side, the single 32-bit Avalon-ST word stream towards the HPS FIFO on the
// other. The master modport is the packer's view; slave is the environment.
interface result_stream_packer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 64
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [31:0]              out_data;
  logic [2:0]               out_channel;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_channel, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_channel, out_last
  );
endinterface

// File: rtl/result_stream_packer.sv
// result_stream_packer: round-robin collection of NUM_CH sample streams into
// one 32-bit word stream. 64-bit samples leave as low word then high word.
// A run accepts n_samples per channel while enable is high; finalizacion
// reports a completed run until enable is released.
module result_stream_packer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     n_samples,
  output logic                 finalizacion,
  result_stream_packer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [CNT_W-1:0]  n_lat;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic              word_idx;
  logic              last_pending;
  logic [31:0]       hi_word;

  logic [NUM_CH-1:0] eligible;
  logic              grant_vld;
  logic [2:0]        grant_idx;
  logic              accept_out;
  logic              final_word;
  logic              buf_room;
  logic              take;
  logic              all_full_next;
  logic [DATA_W-1:0] in_sel;
  logic [31:0]       sel_lo;
  logic [31:0]       sel_hi;

  // Channel may be granted while it has data and its quota is not yet met
  always_comb begin
    eligible = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      eligible[c] = bus.in_valid[c] && (cnt[c] < n_lat);
    end
  end

  // First eligible channel strictly after the pointer, wrapping
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = ({29'd0, ptr} + i) % NUM_CH;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!grant_vld && (c == idx) && eligible[c]) begin
          grant_vld = 1'b1;
          grant_idx = 3'(c);
        end
      end
    end
  end

  assign accept_out = bus.out_valid && bus.out_ready;
  assign final_word = (DATA_W == 32) || word_idx;
  // Buffer can take a sample when empty or when its final word leaves now
  assign buf_room   = !bus.out_valid || (accept_out && final_word);
  assign take       = (state == RUN) && enable && grant_vld && buf_room;
  assign in_sel     = bus.in_data[grant_idx*DATA_W +: DATA_W];
  assign sel_lo     = in_sel[31:0];

  generate
    if (DATA_W == 64) begin : g_hi
      assign sel_hi = in_sel[63:32];
    end else begin : g_no_hi
      assign sel_hi = '0;
    end
  endgenerate

  // One-hot accept towards the granted channel only
  always_comb begin
    bus.in_ready = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.in_ready[c] = take && (grant_idx == 3'(c));
    end
  end

  // Would the sample being taken now fill the last outstanding quota
  always_comb begin
    all_full_next = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (take && (grant_idx == 3'(c))) begin
        if (cnt[c] + CNT_W'(1) != n_lat) all_full_next = 1'b0;
      end else begin
        if (cnt[c] != n_lat) all_full_next = 1'b0;
      end
    end
  end

  // Run control, counters, holding buffer and registered stream outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state           <= IDLE;
      ptr             <= 3'(NUM_CH - 1);
      n_lat           <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      word_idx        <= 1'b0;
      last_pending    <= 1'b0;
      hi_word         <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_channel <= '0;
      bus.out_last    <= 1'b0;
      finalizacion    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finalizacion <= 1'b0;
          if (enable) begin
            n_lat <= n_samples;
            for (int unsigned c = 0; c < NUM_CH; c++) cnt[c] <= '0;
            ptr   <= 3'(NUM_CH - 1);
            state <= (n_samples == '0) ? DONE : RUN;
          end
        end

        RUN: begin
          if (take) begin
            bus.out_valid   <= 1'b1;
            bus.out_data    <= sel_lo;
            bus.out_channel <= grant_idx;
            bus.out_last    <= (DATA_W == 32) && all_full_next;
            hi_word         <= sel_hi;
            word_idx        <= 1'b0;
            last_pending    <= all_full_next;
            ptr             <= grant_idx;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              if ((grant_idx == 3'(c)) && (cnt[c] < n_lat)) cnt[c] <= cnt[c] + CNT_W'(1);
            end
          end else if (accept_out) begin
            if (final_word) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              bus.out_data  <= hi_word;
              bus.out_last  <= last_pending;
              word_idx      <= 1'b1;
            end
          end

          // Completion wins over abort; an abort waits for the buffered
          // sample (both words when 64-bit) to drain before leaving RUN.
          if (accept_out && final_word && last_pending) begin
            state        <= DONE;
            last_pending <= 1'b0;
          end else if (!enable && !take && buf_room) begin
            state <= IDLE;
          end
        end

        DONE: begin
          if (enable) begin
            finalizacion <= 1'b1;
          end else begin
            finalizacion <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/result_stream_packer.md
# result_stream_packer

Parametrised result-to-FIFO packer. It collects samples from NUM_CH processing channels of DATA_W bits each and serialises them onto a single 32-bit Avalon-ST stream feeding the HPS FIFO, with 64-bit samples split into low (down) and high (up) words. It runs a bounded acquisition of n_samples per channel under an enable/finalizacion handshake. It replaces the fixed two-channel 32/64-bit up/down FIFO wiring with one generic block.

## Interface
- NUM_CH, 2: number of input channels, 1..8
- DATA_W, 64: input sample width, 32 or 64 only
- CNT_W, 32: width of the sample counters and n_samples
- clk_clk  in  1  system clock; all logic on the rising edge
- reset_reset_n  in  1  reset, asynchronous and active-low
- enable  in  1  acquisition enable, level-sensitive
- n_samples  in  CNT_W  samples per channel per run; latched on run start
- in_valid  in  NUM_CH  per-channel sample valid
- in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_ready  out  NUM_CH  per-channel accept; a sample transfers when valid&ready
- out_valid  out  1  output word valid
- out_data  out  32  output word
- out_channel  out  3  source channel of the current word
- out_last  out  1  final word of a completed run
- out_ready  in  1  sink accept
- finalizacion  out  1  run complete; held until enable goes low

## Operation
- Clock and reset: one clock, clk_clk. Reset, reset_reset_n, is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 0.
  - If enable = 1: latch n_samples, clear all per-channel counters, and set the round-robin pointer to NUM_CH-1.
  - Next state is RUN, or DONE directly if n_samples = 0. In the n_samples = 0 case no words are emitted.
- RUN, arbitration:
  - A channel is eligible if in_valid[c] = 1 and its count is below the latched n_samples.
  - Grant goes to the first eligible channel strictly after the pointer, wrapping modulo NUM_CH.
  - At most one in_ready bit is high, and only for the granted channel.
  - The pointer updates to the granted channel on each accepted sample.
- RUN, holding buffer:
  - One sample register plus a word index.
  - in_ready is raised when the buffer is empty, or when the buffer's final word is being accepted this cycle (out_valid & out_ready & final word). This gives zero bubble.
  - in_ready may depend combinationally on out_ready.
- Word emission:
  - DATA_W = 32: one word per sample.
  - DATA_W = 64: bits [31:0] first, then [63:32].
  - out_channel carries the source channel on every word of the sample.
  - out_valid, out_data, out_channel and out_last are held stable while out_valid & !out_ready.
- Completion:
  - When every channel's count equals n_samples and the buffer's final word is accepted, the FSM goes to DONE.
  - out_last = 1 only on that final word.
- DONE: finalizacion = 1 and in_ready = 0. On enable = 0, go to IDLE and clear finalizacion.
- Abort: enable falling during RUN.
  - Stop granting immediately.
  - Finish emitting the buffered sample; a 64-bit pair is never split.
  - Then go to IDLE. out_last stays 0 and finalizacion stays 0.
- Counters:
  - Per-channel counters are CNT_W wide and saturate at n_samples; they never wrap.
  - Changes to n_samples during RUN are ignored.
- Channels with no in_valid stall completion indefinitely. This is intended; software aborts via enable.

## Timing
- Reset values:
  - Outputs: in_ready 0, out_valid 0, out_data 0, out_channel 0, out_last 0, finalizacion 0.
  - Internal: state IDLE, pointer NUM_CH-1, counters 0.
- Run start: enable sampled high in IDLE → RUN on the next edge. The first in_ready can be high in the cycle after that.
- Latency: input handshake at edge k → out_valid high after edge k, i.e. 1 cycle, registered.
- Throughput:
  - DATA_W = 32: 1 sample per cycle with out_ready held high.
  - DATA_W = 64: 1 sample per 2 cycles.
- finalizacion rises on the edge after the final word is accepted.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous). A partial pair is discarded.

## Test plan
- DATA_W = 64, NUM_CH = 2, n_samples = 3; both channels always valid; ch0 data 0x11112222_33334444, ch1 0xAAAABBBB_CCCCDDDD; out_ready = 1 → 12 words alternating ch0/ch1. Word order is low then high (0x33334444, 0x11112222, ...). out_last is on word 12 only. finalizacion rises 1 cycle later.
- Backpressure: same setup, out_ready toggled 1/0 every cycle → same 12 words in the same order. Outputs hold stable during stalls, and in_ready never overlaps a non-empty buffer that is not draining.
- Round-robin fairness: NUM_CH = 4, only ch1 and ch3 valid, n_samples = 2 → grant order 1, 3, 1, 3. The run does not complete until ch0/ch2 supply 2 samples each.
- DATA_W = 32, n_samples = 0 → no words emitted. finalizacion = 1 two cycles after enable rises; clears 1 cycle after enable drops.
- Abort: enable dropped while the low word of a 64-bit sample is pending → the high word is still emitted. out_last = 0, finalizacion = 0, FSM returns to IDLE, and in_ready stays 0.
- Asynchronous reset asserted mid-pair → out_valid = 0 without waiting for a clock edge. After release the FSM is in IDLE; re-enabling restarts from channel 0 with counters at 0.
